// File: rtl/qracc_output_collector.sv
// Result collector for the sequential MAC accelerator: captures unthrottled result
// pulses into a small FIFO, issues a credit stall, and drains vectors as narrow beats.
module qracc_output_collector #(
  parameter int outputElements = 32,
  parameter int outputBits     = 4,
  parameter int laneWidth      = 8,
  parameter int fifoDepth      = 4,
  localparam int numBeats      = outputElements / laneWidth,
  localparam int beatW         = (numBeats > 1) ? $clog2(numBeats) : 1,
  localparam int cntW          = $clog2(fifoDepth) + 1
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             clr_err_i,
  input  logic                             acc_issue_i,
  input  logic                             mac_valid_i,
  input  logic [outputElements*outputBits-1:0] mac_data_i,
  output logic                             stall_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [laneWidth*outputBits-1:0]  out_data_o,
  output logic [beatW-1:0]                 out_beat_o,
  output logic                             out_last_o,
  output logic [cntW-1:0]                  fifo_count_o,
  output logic [1:0]                       err_o
);

  localparam int vecW     = outputElements * outputBits;
  localparam int beatBits = laneWidth * outputBits;
  localparam int ptrW     = $clog2(fifoDepth);

  localparam logic [cntW-1:0]  depthCnt = cntW'(fifoDepth);
  localparam logic [beatW-1:0] lastBeat = beatW'(numBeats - 1);

  if (outputElements % laneWidth != 0) begin : g_bad_lanes
    $error("outputElements must be a multiple of laneWidth");
  end
  if (fifoDepth < 2 || (fifoDepth & (fifoDepth - 1)) != 0) begin : g_bad_depth
    $error("fifoDepth must be a power of two and at least 2");
  end

  logic [vecW-1:0]  mem [fifoDepth];
  logic [vecW-1:0]  head;
  logic [ptrW-1:0]  wr_ptr;
  logic [ptrW-1:0]  rd_ptr;
  logic [cntW-1:0]  count;
  logic [cntW-1:0]  inflight;
  logic [beatW-1:0] beat;
  logic [1:0]       err;
  logic [cntW:0]    occupancy;

  logic handshake;
  logic pop;
  logic push;
  logic overflow;
  logic orphan;

  always_comb begin
    handshake = out_valid_o && out_ready_i;
    pop       = handshake && out_last_o;
    // A full FIFO still accepts a result when the head vector leaves in the same cycle.
    push      = mac_valid_i && ((count < depthCnt) || pop);
    overflow  = mac_valid_i && !push;
    // A same-cycle issue supplies the credit for the arriving result.
    orphan    = mac_valid_i && !acc_issue_i && (inflight == '0);
    occupancy = {1'b0, count} + {1'b0, inflight};
  end

  assign head         = mem[rd_ptr];
  assign out_valid_o  = (count != '0);
  assign out_beat_o   = beat;
  assign out_last_o   = out_valid_o && (beat == lastBeat);
  assign out_data_o   = head[int'(beat)*beatBits +: beatBits];
  assign stall_o      = (occupancy >= {1'b0, depthCnt});
  assign fifo_count_o = count;
  assign err_o        = err;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= mac_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + cntW'(1);
        2'b01:   count <= count - cntW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      beat <= '0;
    end else if (handshake) begin
      beat <= out_last_o ? '0 : beat + beatW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      inflight <= '0;
    end else if (acc_issue_i && !mac_valid_i) begin
      if (inflight != depthCnt) begin
        inflight <= inflight + cntW'(1);
      end
    end else if (mac_valid_i && !acc_issue_i) begin
      if (inflight != '0) begin
        inflight <= inflight - cntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      err <= '0;
    end else if (clr_err_i) begin
      err <= {orphan, overflow};
    end else begin
      err <= err | {orphan, overflow};
    end
  end

endmodule
